// File: rtl/led_fade_pwm.sv
// Per-LED PWM fade stage: each of the 16 LEDs ramps a brightness level toward
// the on/off target given by the rotator pattern and drives a PWM of that level.
module led_fade_pwm #(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 390625
) (
  input  logic        clk100m,
  input  logic        rstn,
  input  logic [15:0] pattern_in,
  input  logic        pattern_valid,
  input  logic        fade_en,
  output logic [15:0] leds_out,
  output logic        settled
);

  localparam int                  NUM_LEDS  = 16;
  localparam int                  STEP_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;
  localparam logic [PWM_BITS-1:0] LVL_MIN   = '0;
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    CH_OFF,
    CH_RAMP_UP,
    CH_ON,
    CH_RAMP_DOWN
  } ch_state_e;

  logic [15:0]         target_q, target_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic [PWM_BITS-1:0] level_q [NUM_LEDS];
  logic [PWM_BITS-1:0] level_d [NUM_LEDS];
  ch_state_e           ch_state [NUM_LEDS];
  logic                step_tick;
  logic [15:0]         leds_q, leds_d;
  logic                settled_q, settled_d;

  always_comb begin
    step_tick  = (step_cnt_q == STEP_LAST);
    pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
    step_cnt_d = step_tick ? '0 : step_cnt_q + STEP_W'(1);
    target_d   = pattern_valid ? pattern_in : target_q;
  end

  // Channel state is derived from level and target; nothing extra is stored.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (target_q[i]) begin
        ch_state[i] = (level_q[i] == LVL_MAX) ? CH_ON : CH_RAMP_UP;
      end else begin
        ch_state[i] = (level_q[i] == LVL_MIN) ? CH_OFF : CH_RAMP_DOWN;
      end
    end
  end

  // Uses target_q, so a capture landing on a step tick only steers later ticks.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      // NOTE: default first so every path assigns level_d; a missing branch would infer a latch.
      level_d[i] = level_q[i];
      if (!fade_en) begin
        level_d[i] = target_q[i] ? LVL_MAX : LVL_MIN;
      end else if (step_tick) begin
        case (ch_state[i])
          CH_RAMP_UP:   level_d[i] = level_q[i] + PWM_BITS'(1);
          CH_RAMP_DOWN: level_d[i] = level_q[i] - PWM_BITS'(1);
          default:      level_d[i] = level_q[i];
        endcase
      end
    end
  end

  // MAX is forced high so a full-on LED never blinks at the PWM wrap.
  always_comb begin
    leds_d    = '0;
    settled_d = 1'b1;
    for (int i = 0; i < NUM_LEDS; i++) begin
      leds_d[i] = (level_q[i] == LVL_MAX) || (level_q[i] > pwm_cnt_q);
      if (level_q[i] != (target_q[i] ? LVL_MAX : LVL_MIN)) begin
        settled_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk100m or negedge rstn) begin
    if (!rstn) begin
      target_q   <= '0;
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
      leds_q     <= '0;
      settled_q  <= 1'b1;
      // NOTE: the level array is a bank of flops, not a RAM, so it is cleared by reset like any register.
      for (int i = 0; i < NUM_LEDS; i++) begin
        level_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      target_q   <= target_d;
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      leds_q     <= leds_d;
      settled_q  <= settled_d;
      for (int i = 0; i < NUM_LEDS; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end

  assign leds_out = leds_q;
  assign settled  = settled_q;

endmodule
